// File: rtl/lego_sa_pkg.sv
// ----------------------------------------------------------------------------
// lego_sa_pkg
// Shared types and constants for the Lego systolic-array scheduler.
//   lego_sched_state_e : scheduler FSM states (also exported on dbg_state)
//   lego_type_e        : array partition mode (FULL/HALF/QUAD)
//   lanes_for_type()   : number of valid psum lanes for a mode
//   LEGO_* constants   : default weight-beat count, pipe latency, count width
// ----------------------------------------------------------------------------
package lego_sa_pkg;

   localparam int unsigned LEGO_W_BEATS  = 16;
   localparam int unsigned LEGO_PIPE_LAT = 33;
   localparam int unsigned LEGO_CNT_W    = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } lego_sched_state_e;

   typedef enum logic [1:0] {
      FULL = 2'd0,
      HALF = 2'd1,
      QUAD = 2'd2
   } lego_type_e;

   // Mode encoding 3 has no array configuration behind it.
   localparam logic [1:0] TYPE_ILLEGAL = 2'd3;

   function automatic logic [6:0] lanes_for_type(input logic [1:0] mode);
      case (mode)
         FULL:    return 7'd64;
         HALF:    return 7'd32;
         QUAD:    return 7'd16;
         default: return 7'd0;
      endcase
   endfunction

endpackage

// File: rtl/lego_valid_pipe.sv
// ----------------------------------------------------------------------------
// lego_valid_pipe
// DEPTH-stage 1-bit shift register that tracks in-flight activation beats so
// the scheduler can flag the matching psum at the array output.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of every stage (job kill)
//   din        : accepted-beat marker entering stage 0
//   dout       : last stage; high when the psum for that beat is valid
//   all_zero   : no beat remains behind the output stage, i.e. once the
//                current dout has been emitted the line is empty
// ----------------------------------------------------------------------------
module lego_valid_pipe #(
   parameter int unsigned DEPTH = 33
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic din,
   output logic dout,
   output logic all_zero
);

   localparam logic [DEPTH-1:0] OUT_BIT = DEPTH'(1) << (DEPTH - 1);

   logic [DEPTH-1:0] line_q;
   logic [DEPTH-1:0] line_d;

   // Shifts every cycle; a cycle with no accepted beat enters as a 0 bubble.
   always_comb begin
      line_d = (line_q << 1) | DEPTH'(din);
      if (clr) begin
         line_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   assign dout = line_q[DEPTH-1];

   // Looking past the output stage lets the owner leave its drain state in
   // the same cycle the final valid is emitted.
   assign all_zero = ((line_q & ~OUT_BIT) == '0);

endmodule

// File: rtl/lego_sa_scheduler.sv
// ----------------------------------------------------------------------------
// lego_sa_scheduler
// Job sequencer for the 64-lane Lego systolic array: weight-load phase,
// activation streaming, in-flight tracking and job completion.
//   clk, rst_n             : clock, asynchronous active-low reset
//   start, cfg_type,
//   cfg_transpose,
//   cfg_n_act              : job request and its configuration (IDLE only)
//   abort                  : synchronous job kill (ignored in IDLE)
//   w_valid / w_ready      : weight-buffer handshake
//   a_valid / a_ready      : activation-buffer handshake
//   sa_valid_in, sa_load_w,
//   sa_type, sa_transpose_en : array controls
//   out_valid, out_lanes   : psum-valid strobe and lane count for the job
//   busy, done, err        : status (done/err are 1-cycle pulses)
//   dbg_state              : current FSM state
//
// Handshakes: a beat transfers in a cycle where valid and ready are both
// high. Readies are Moore functions of state and counters only and never
// depend on the matching valid; valid is never required to wait for ready.
// ----------------------------------------------------------------------------
module lego_sa_scheduler
   import lego_sa_pkg::*;
#(
   parameter int unsigned W_BEATS  = LEGO_W_BEATS,
   parameter int unsigned PIPE_LAT = LEGO_PIPE_LAT,
   parameter int unsigned CNT_W    = LEGO_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        cfg_type,
   input  logic              cfg_transpose,
   input  logic [CNT_W-1:0]  cfg_n_act,
   input  logic              abort,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic              a_valid,
   output logic              a_ready,
   output logic              sa_valid_in,
   output logic              sa_load_w,
   output logic [1:0]        sa_type,
   output logic              sa_transpose_en,
   output logic              out_valid,
   output logic [6:0]        out_lanes,
   output logic              busy,
   output logic              done,
   output logic              err,
   output lego_sched_state_e dbg_state
);

   localparam int unsigned      WCNT_W = $clog2(W_BEATS + 1);
   localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(W_BEATS - 1);

   lego_sched_state_e state_q, state_d;

   logic [WCNT_W-1:0] w_cnt_q, w_cnt_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [1:0]        type_q, type_d;
   logic              transpose_q, transpose_d;
   logic              err_q, err_d;

   logic start_ok;
   logic start_bad;
   logic kill;
   logic w_fire;
   logic a_fire;
   logic w_last;
   logic a_last;
   logic pipe_all_zero;

   assign start_ok  = (state_q == ST_IDLE) && start && (cfg_type != TYPE_ILLEGAL);
   assign start_bad = (state_q == ST_IDLE) && start && (cfg_type == TYPE_ILLEGAL);
   assign kill      = abort && (state_q != ST_IDLE);
   assign w_fire    = w_valid && w_ready;
   assign a_fire    = a_valid && a_ready;
   assign w_last    = w_fire && (w_cnt_q == W_LAST);
   assign a_last    = a_fire && (rem_q == CNT_W'(1));

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) state_d = ST_LOAD_W;
         end
         ST_LOAD_W: begin
            // rem_q still holds the full job size here; zero means skip STREAM.
            if (w_last) state_d = (rem_q == '0) ? ST_DONE : ST_STREAM;
         end
         ST_STREAM: begin
            if (a_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pipe_all_zero) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (kill) begin
         state_d = ST_IDLE;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   always_comb begin
      w_ready     = 1'b0;
      a_ready     = 1'b0;
      sa_load_w   = 1'b0;
      sa_valid_in = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
         end
         ST_LOAD_W: begin
            w_ready     = 1'b1;
            sa_load_w   = 1'b1;
            sa_valid_in = w_valid;
         end
         ST_STREAM: begin
            a_ready     = (rem_q != '0);
            sa_valid_in = a_valid && (rem_q != '0);
         end
         ST_DRAIN: begin
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Counters, latched job configuration and the err pulse
   // -------------------------------------------------------------------------
   always_comb begin
      w_cnt_d     = w_cnt_q;
      rem_d       = rem_q;
      type_d      = type_q;
      transpose_d = transpose_q;
      err_d       = start_bad;
      if (start_ok) begin
         type_d      = cfg_type;
         transpose_d = cfg_transpose;
         rem_d       = cfg_n_act;
         w_cnt_d     = '0;
      end
      if (w_fire) begin
         w_cnt_d = w_cnt_q + 1'b1;
      end
      if (a_fire) begin
         rem_d = rem_q - 1'b1;
      end
      // A beat accepted in the abort cycle is dropped, not counted.
      if (kill) begin
         w_cnt_d = '0;
         rem_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_cnt_q     <= '0;
         rem_q       <= '0;
         type_q      <= '0;
         transpose_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         w_cnt_q     <= w_cnt_d;
         rem_q       <= rem_d;
         type_q      <= type_d;
         transpose_q <= transpose_d;
         err_q       <= err_d;
      end
   end

   // -------------------------------------------------------------------------
   // In-flight tracking: one bit per accepted activation beat
   // -------------------------------------------------------------------------
   lego_valid_pipe #(
      .DEPTH (PIPE_LAT)
   ) u_valid_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (kill),
      .din      (a_fire),
      .dout     (out_valid),
      .all_zero (pipe_all_zero)
   );

   assign sa_type         = type_q;
   assign sa_transpose_en = transpose_q;
   assign out_lanes       = busy ? lanes_for_type(type_q) : 7'd0;
   assign err             = err_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_lego_sa_scheduler.sv
// ----------------------------------------------------------------------------
// tb_lego_sa_scheduler
// Directed bench for lego_sa_scheduler. Each job is described by per-cycle
// masks (start, w_valid, a_valid, abort) relative to the start cycle, plus
// the cycles at which the bench expects an activation to be accepted; those
// push the matching out_valid cycle onto the scoreboard queue.
// ----------------------------------------------------------------------------
module tb_lego_sa_scheduler;
   import lego_sa_pkg::*;

   localparam int W_BEATS  = 16;
   localparam int PIPE_LAT = 33;
   localparam int CNT_W    = 16;

   // ---------------------------------------------------------------- clock/reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- DUT
   logic              start = 1'b0;
   logic [1:0]        cfg_type = 2'd0;
   logic              cfg_transpose = 1'b0;
   logic [CNT_W-1:0]  cfg_n_act = '0;
   logic              abort = 1'b0;
   logic              w_valid = 1'b0;
   logic              a_valid = 1'b0;
   logic              w_ready, a_ready, sa_valid_in, sa_load_w;
   logic [1:0]        sa_type;
   logic              sa_transpose_en, out_valid;
   logic [6:0]        out_lanes;
   logic              busy, done, err;
   lego_sched_state_e dbg_state;

   lego_sa_scheduler #(
      .W_BEATS  (W_BEATS),
      .PIPE_LAT (PIPE_LAT),
      .CNT_W    (CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .cfg_type        (cfg_type),
      .cfg_transpose   (cfg_transpose),
      .cfg_n_act       (cfg_n_act),
      .abort           (abort),
      .w_valid         (w_valid),
      .w_ready         (w_ready),
      .a_valid         (a_valid),
      .a_ready         (a_ready),
      .sa_valid_in     (sa_valid_in),
      .sa_load_w       (sa_load_w),
      .sa_type         (sa_type),
      .sa_transpose_en (sa_transpose_en),
      .out_valid       (out_valid),
      .out_lanes       (out_lanes),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .dbg_state       (dbg_state)
   );

   // ---------------------------------------------------------------- scoreboard
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // Every out_valid must land on the cycle at the head of the queue.
   task automatic ov_monitor();
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0 && exp_q[0] == cyc) begin
            void'(exp_q.pop_front());
            check("out_valid_hit", {31'b0, out_valid}, 32'd1);
         end else if (out_valid !== 1'b0) begin
            check("out_valid_spurious", {31'b0, out_valid}, 32'd0);
         end
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rng(input int lo, input int hi);
      logic [127:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [127:0] bit_at(input int i);
      logic [127:0] m;
      m = '0;
      m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] all_outs();
      return 32'({w_ready, a_ready, sa_valid_in, sa_load_w, sa_type, sa_transpose_en,
                  out_valid, out_lanes, busy, done, err});
   endfunction

   // Runs n_win cycles from the start cycle (r=0) and checks the job-level
   // observations against the expected values (-1 = never happens).
   task automatic run_job(input string tag, input int n_win,
                          input logic [1:0] typ, input logic tr, input logic [CNT_W-1:0] n_act,
                          input logic [127:0] sv, input logic [127:0] wv, input logic [127:0] av,
                          input logic [127:0] ab, input logic [127:0] acc,
                          input int e_load, input int e_stream, input int e_aready,
                          input int e_done, input int e_err, input int e_first_busy,
                          input int e_last_busy, input logic [6:0] e_lanes);
      int t0, load_n, stream_n, aready_r, done_r, done_n, err_r, err_n;
      int fb, lb, cfg_bad, idle_bad, hs_bad;
      t0 = 0; load_n = 0; stream_n = 0; aready_r = -1; done_r = -1; done_n = 0;
      err_r = -1; err_n = 0; fb = -1; lb = -1; cfg_bad = 0; idle_bad = 0; hs_bad = 0;
      for (int r = 0; r < n_win; r++) begin
         tick();
         if (r == 0) t0 = cyc;
         start   = sv[r];
         abort   = ab[r];
         w_valid = wv[r];
         a_valid = av[r];
         if (r == 0) begin
            cfg_type      = typ;
            cfg_transpose = tr;
            cfg_n_act     = n_act;
         end else begin
            cfg_type      = 2'($urandom_range(0, 3));
            cfg_transpose = 1'($urandom_range(0, 1));
            cfg_n_act     = CNT_W'($urandom_range(0, 65535));
         end
         if (acc[r]) exp_q.push_back(32'(t0 + r + PIPE_LAT));
         @(negedge clk);
         if (sa_load_w === 1'b1) load_n++;
         if (sa_valid_in === 1'b1 && sa_load_w === 1'b0) stream_n++;
         if (a_ready === 1'b1 && aready_r < 0) aready_r = r;
         if (done === 1'b1) begin done_n++; done_r = r; end
         if (err === 1'b1) begin err_n++; err_r = r; end
         if (w_ready !== sa_load_w) hs_bad++;
         if (busy === 1'b1) begin
            if (fb < 0) fb = r;
            lb = r;
            if (sa_type !== typ || sa_transpose_en !== tr || out_lanes !== e_lanes) cfg_bad++;
         end else if ({w_ready, a_ready, sa_load_w, sa_valid_in, done, out_lanes} !== '0) begin
            idle_bad++;
         end
      end
      start = 1'b0; abort = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
      check({tag, "_load_w_cycles"}, load_n, e_load);
      check({tag, "_stream_valid_cycles"}, stream_n, e_stream);
      check({tag, "_a_ready_first"}, aready_r, e_aready);
      check({tag, "_done_cycle"}, done_r, e_done);
      check({tag, "_done_pulses"}, done_n, (e_done < 0) ? 0 : 1);
      check({tag, "_err_cycle"}, err_r, e_err);
      check({tag, "_err_pulses"}, err_n, (e_err < 0) ? 0 : 1);
      check({tag, "_busy_first"}, fb, e_first_busy);
      check({tag, "_busy_last"}, lb, e_last_busy);
      check({tag, "_cfg_stable"}, cfg_bad, 0);
      check({tag, "_idle_quiet"}, idle_bad, 0);
      check({tag, "_w_ready_eq_load_w"}, hs_bad, 0);
   endtask

   // ---------------------------------------------------------------- sequence
   logic [127:0] all_ones;
   logic [127:0] none;
   int           bad;

   initial begin
      all_ones = rng(0, 127);
      none     = '0;
      fork
         ov_monitor();
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_outputs", all_outs(), 32'd0);
      check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
      rst_n = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      check("post_reset_outputs", all_outs(), 32'd0);

      // Nominal: mode 0, 4 vectors, no stalls; a second start (random cfg)
      // during LOAD_W must be ignored without err.
      run_job("nominal", 60, 2'd0, 1'b1, 16'd4,
              bit_at(0) | bit_at(5), all_ones, all_ones, none, rng(17, 20),
              16, 4, 17, 54, -1, 1, 54, 7'd64);

      // Stalls: mode 1, 3 vectors, w_valid low r=5..7, a_valid 1,0,1,0,1
      run_job("stalls", 65, 2'd1, 1'b0, 16'd3,
              bit_at(0), all_ones & ~rng(5, 7), all_ones & ~bit_at(21) & ~bit_at(23),
              none, bit_at(20) | bit_at(22) | bit_at(24),
              19, 3, 20, 58, -1, 1, 58, 7'd32);

      // Illegal mode
      run_job("illegal", 8, 2'd3, 1'b1, 16'd5,
              bit_at(0), all_ones, all_ones, none, none,
              0, 0, -1, -1, 1, -1, -1, 7'd0);

      // Abort at the 2nd STREAM cycle with one vector in flight; the
      // in-flight vector must never appear on out_valid.
      run_job("abort", 60, 2'd0, 1'b1, 16'd4,
              bit_at(0), all_ones, all_ones, bit_at(18), none,
              16, 2, 17, -1, -1, 1, 18, 7'd64);

      // Zero count right after the abort
      run_job("zero", 25, 2'd2, 1'b0, 16'd0,
              bit_at(0), all_ones, all_ones, none, none,
              16, 0, -1, 17, -1, 1, 17, 7'd16);

      // Mid-job reset while draining
      run_job("rst", 30, 2'd2, 1'b1, 16'd2,
              bit_at(0), all_ones, all_ones, none, none,
              16, 2, 17, -1, -1, 1, 29, 7'd16);
      tick();
      check("rst_pre_state", 32'(dbg_state), 32'(ST_DRAIN));
      #2 rst_n = 1'b0;
      #1;
      check("rst_outputs_async", all_outs(), 32'd0);
      check("rst_state_async", 32'(dbg_state), 32'(ST_IDLE));
      repeat (3) tick();
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         @(negedge clk);
         if (busy !== 1'b0 || out_valid !== 1'b0 || dbg_state !== ST_IDLE) bad++;
      end
      check("post_rst_quiet", bad, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
